// File: rtl/sched_pkg.sv
// ---------------------------------------------------------------------------
// sched_pkg
// Shared definitions for the task scheduler slice: op-word opcodes, op field
// positions, the dispatcher FSM state type and a helper that packs op words.
// Ports: none (package).
// ---------------------------------------------------------------------------
package sched_pkg;

  // Opcodes carried in bits [7:4] of every op word on the shared bus
  localparam logic [3:0] OP_READY   = 4'h1;
  localparam logic [3:0] OP_SUSPEND = 4'h2;
  localparam logic [3:0] OP_WAIT    = 4'h3;
  localparam logic [3:0] OP_KILL    = 4'h4;
  localparam logic [3:0] OP_PRIO    = 4'h5;
  localparam logic [3:0] OP_EXEHIT  = 4'h6;
  localparam logic [3:0] OP_EXEC    = 4'h7;
  localparam logic [3:0] OP_FINISH  = 4'hF;

  // Op word layout: [15:12] zero, [11:8] task id, [7:4] opcode, [3:0] argument
  localparam int OP_ID_LSB   = 8;
  localparam int OP_CODE_LSB = 4;
  localparam int OP_ARG_LSB  = 0;
  localparam int OP_W        = 16;

  // Sorter word layout: [7:4] id, [3:0] priority; id 0 marks an empty slot
  localparam int SLOT_WORD_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_DISPATCH,
    ST_RUN,
    ST_RETIRE
  } state_t;

  function automatic logic [OP_W-1:0] makeOp(input logic [3:0] id,
                                             input logic [3:0] code,
                                             input logic [3:0] arg);
    return {4'h0, id, code, arg};
  endfunction

endpackage

// File: rtl/task_dispatcher_prio_select.sv
// ---------------------------------------------------------------------------
// prio_select
// Combinational finder for the highest-priority ready task slot. Ties are
// broken round-robin: the scan starts at last_slot+1 and wraps, so the slot
// served last time is picked again only when it alone holds the maximum.
// Ports:
//   task_words  in  packed sorter words, slot k at [8k+7:8k] = {id, prio}
//   last_slot   in  slot that received the previous dispatch
//   found       out at least one slot has a non-zero id
//   slot        out index of the winning slot
//   id          out id field of the winning slot
// ---------------------------------------------------------------------------
module prio_select
  import sched_pkg::*;
#(
  parameter int N_TASKS = 8,
  parameter int SLOT_W  = (N_TASKS > 1) ? $clog2(N_TASKS) : 1
) (
  input  logic [SLOT_WORD_W*N_TASKS-1:0] task_words,
  input  logic [SLOT_W-1:0]              last_slot,
  output logic                           found,
  output logic [SLOT_W-1:0]              slot,
  output logic [3:0]                     id
);

  localparam logic [SLOT_W:0] NUM_SLOTS = (SLOT_W+1)'(N_TASKS);

  logic [SLOT_WORD_W-1:0] w_words [N_TASKS];
  logic [SLOT_W:0]        w_sum;
  logic [SLOT_W-1:0]      w_idx;
  logic [SLOT_WORD_W-1:0] w_word;
  logic [3:0]             w_bestPrio;

  // Unpack the sorter bus so the scan can index slots directly
  for (genvar k = 0; k < N_TASKS; k++) begin : g_unpack
    assign w_words[k] = task_words[SLOT_WORD_W*k +: SLOT_WORD_W];
  end

  // Scan all slots in round-robin order; a later slot only replaces the
  // current best on a strictly higher priority, which yields the tie rule
  always_comb begin
    found      = 1'b0;
    slot       = '0;
    id         = '0;
    w_bestPrio = '0;
    w_sum      = '0;
    w_idx      = '0;
    w_word     = '0;
    for (int i = 1; i <= N_TASKS; i++) begin
      w_sum = {1'b0, last_slot} + (SLOT_W+1)'(i);
      if (w_sum >= NUM_SLOTS) begin
        w_sum = w_sum - NUM_SLOTS;
      end
      w_idx  = w_sum[SLOT_W-1:0];
      w_word = w_words[w_idx];
      if ((w_word[7:4] != 4'h0) && (!found || (w_word[3:0] > w_bestPrio))) begin
        found      = 1'b1;
        slot       = w_idx;
        id         = w_word[7:4];
        w_bestPrio = w_word[3:0];
      end
    end
  end

endmodule

// File: rtl/task_dispatcher.sv
// ---------------------------------------------------------------------------
// task_dispatcher
// Scheduler above the per-task FSMs. Picks the highest-priority ready task,
// drives Execute to it, lets it run for one time slice and then drives
// Finish. The same registered op bus also carries host-issued ops whenever
// the scheduler is not emitting one of its own.
// Ports:
//   CLK, RST        clock, asynchronous active-high reset
//   en              scheduling enable; low blocks new dispatches only
//   task_words      packed {id, prio} sorter words, id 0 = not ready
//   host_op         host op word, taken when host_op_valid && host_op_ready
//   host_op_valid   host op request
//   host_op_ready   host may use the bus this cycle
//   out_op          registered op bus to all tasks (0 = no-op)
//   running_valid   a task currently holds the slice
//   running_id      id of the running task
//   dispatch_cnt    saturating count of Execute ops issued
// ---------------------------------------------------------------------------
module task_dispatcher
  import sched_pkg::*;
#(
  parameter int N_TASKS      = 8,
  parameter int SLICE_CYCLES = 1000,
  parameter int CNT_W        = 16
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           en,
  input  logic [SLOT_WORD_W*N_TASKS-1:0] task_words,
  input  logic [OP_W-1:0]                host_op,
  input  logic                           host_op_valid,
  output logic                           host_op_ready,
  output logic [OP_W-1:0]                out_op,
  output logic                           running_valid,
  output logic [3:0]                     running_id,
  output logic [CNT_W-1:0]               dispatch_cnt
);

  localparam int SLOT_W  = (N_TASKS > 1) ? $clog2(N_TASKS) : 1;
  localparam int SLICE_W = $clog2(SLICE_CYCLES);
  localparam logic [SLICE_W-1:0] SLICE_LAST = SLICE_W'(SLICE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

  state_t             r_state;
  logic [SLOT_W-1:0]  r_lastSlot;
  logic [SLOT_W-1:0]  r_winSlot;
  logic [3:0]         r_winId;
  logic [SLICE_W-1:0] r_sliceCnt;

  logic              w_found;
  logic [SLOT_W-1:0] w_slot;
  logic [3:0]        w_id;
  logic [3:0]        w_ids [N_TASKS];
  logic              w_earlyExit;
  logic              w_hostAccept;

  prio_select #(
    .N_TASKS (N_TASKS),
    .SLOT_W  (SLOT_W)
  ) u_prio_select (
    .task_words (task_words),
    .last_slot  (r_lastSlot),
    .found      (w_found),
    .slot       (w_slot),
    .id         (w_id)
  );

  // Id field of every slot, used to watch the running task's slot
  for (genvar k = 0; k < N_TASKS; k++) begin : g_ids
    assign w_ids[k] = task_words[SLOT_WORD_W*k + 4 +: 4];
  end

  // The slice ends early when the winner's slot empties or is reused by a
  // different task, e.g. after a host Suspend/Wait/Kill aimed at it
  assign w_earlyExit = (w_ids[r_winSlot] != r_winId);

  // Scheduler ops own the bus in DISPATCH and RETIRE; the host is held off
  // there and while reset is asserted
  assign host_op_ready = !RST && ((r_state == ST_IDLE) ||
                                  (r_state == ST_SELECT) ||
                                  (r_state == ST_RUN));
  assign w_hostAccept  = host_op_valid && host_op_ready;

  // Dispatcher FSM with registered bus and status outputs. The bus defaults
  // to the accepted host op (or no-op); scheduler states override it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state       <= ST_IDLE;
      r_lastSlot    <= '0;
      r_winSlot     <= '0;
      r_winId       <= '0;
      r_sliceCnt    <= '0;
      out_op        <= '0;
      running_valid <= 1'b0;
      running_id    <= '0;
      dispatch_cnt  <= '0;
    end else begin
      out_op <= w_hostAccept ? host_op : '0;
      case (r_state)
        ST_IDLE: begin
          if (en && w_found) begin
            r_state <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (w_found) begin
            r_winSlot <= w_slot;
            r_winId   <= w_id;
            r_state   <= ST_DISPATCH;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_DISPATCH: begin
          out_op        <= makeOp(r_winId, OP_EXEC, 4'h0);
          running_valid <= 1'b1;
          running_id    <= r_winId;
          if (dispatch_cnt != CNT_MAX) begin
            dispatch_cnt <= dispatch_cnt + CNT_W'(1);
          end
          r_lastSlot    <= r_winSlot;
          r_sliceCnt    <= '0;
          r_state       <= ST_RUN;
        end
        ST_RUN: begin
          if (w_earlyExit || (r_sliceCnt == SLICE_LAST)) begin
            r_state <= ST_RETIRE;
          end else begin
            r_sliceCnt <= r_sliceCnt + SLICE_W'(1);
          end
        end
        ST_RETIRE: begin
          out_op        <= makeOp(r_winId, OP_FINISH, 4'h0);
          running_valid <= 1'b0;
          r_state       <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
